pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline. It generates per-register hold and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken branches/jumps and multi-cycle data-memory accesses, with a timeout watchdog and saturating performance counters. It sits beside the datapath and observes decode fields from ID, writeback info from EX, and the data-memory handshake from MEM.

---
 rtl/pipe_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall/flush controller for a five-stage pipeline. It handles
//            load-use, redirect and data-memory wait hazards, with a timeout
//            watchdog and saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_rf_we,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_hold,
    output logic             if_id_hold,
    output logic             id_ex_hold,
    output logic             ex_mem_hold,
    output logic             if_id_bubble,
    output logic             id_ex_bubble,
    output logic             mem_wb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int               c_wait_w  = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic [c_wait_w-1:0] w_wait_cnt_nxt;
    logic                r_mem_err;
    logic                w_err_set;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;
    logic                w_load_use;
    logic                w_mem_stall;
    logic                w_flush_evt;
    logic                w_any_hold;

    assign w_load_use = ex_is_load & ex_rf_we & (ex_rd != 5'd0) &
                        ((id_rs1_used & (id_rs1 == ex_rd)) |
                         (id_rs2_used & (id_rs2 == ex_rd)));

    assign w_mem_stall = ((r_state == ST_WAIT) & ~mem_ready) |
                         ((r_state == ST_IDLE) & mem_req & ~mem_ready) |
                         (r_state == ST_ERR);

    // Pipeline controls: one action per cycle, memory stall dominates
    always_comb begin
        pc_hold       = 1'b0;
        if_id_hold    = 1'b0;
        id_ex_hold    = 1'b0;
        ex_mem_hold   = 1'b0;
        if_id_bubble  = 1'b0;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;
        w_flush_evt   = 1'b0;
        if (!rst) begin
            if (w_mem_stall) begin
                pc_hold       = 1'b1;
                if_id_hold    = 1'b1;
                id_ex_hold    = 1'b1;
                ex_mem_hold   = 1'b1;
                mem_wb_bubble = 1'b1;
            end else if (ex_redirect) begin
                if_id_bubble = 1'b1;
                id_ex_bubble = 1'b1;
                w_flush_evt  = 1'b1;
            end else if (w_load_use) begin
                pc_hold      = 1'b1;
                if_id_hold   = 1'b1;
                id_ex_bubble = 1'b1;
            end
        end
    end

    assign w_any_hold = pc_hold | if_id_hold | id_ex_hold | ex_mem_hold;

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_err_set      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_req && !mem_ready) begin
                    w_state_nxt    = ST_WAIT;
                    w_wait_cnt_nxt = c_wait_w'(1);
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_wait_cnt == c_wait_w'(MAX_WAIT)) begin
                    w_state_nxt = ST_ERR;
                    w_err_set   = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + c_wait_w'(1);
                end
            end
            ST_ERR:  w_state_nxt = ST_ERR;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= '0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_err_set) begin
                r_mem_err <= 1'b1;
            end
            if (w_any_hold && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_evt && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign mem_err   = r_mem_err;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed self-checking bench for pipe_hazard_ctrl
//            (MAX_WAIT=4, CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;

    // ctl = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_bubble, id_ex_bubble, mem_wb_bubble}
    localparam logic [6:0] CTL_NONE  = 7'b0000_000;
    localparam logic [6:0] CTL_MEM   = 7'b1111_001;
    localparam logic [6:0] CTL_REDIR = 7'b0000_110;
    localparam logic [6:0] CTL_LU    = 7'b1100_010;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic             ex_rf_we;
    logic             ex_is_load;
    logic [4:0]       ex_rd;
    logic             ex_redirect;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_hold;
    logic             if_id_hold;
    logic             id_ex_hold;
    logic             ex_mem_hold;
    logic             if_id_bubble;
    logic             id_ex_bubble;
    logic             mem_wb_bubble;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [6:0]       ctl;

    int n_pass;
    int n_total;

    pipe_hazard_ctrl #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rs1_used   (id_rs1_used),
        .id_rs2_used   (id_rs2_used),
        .ex_rf_we      (ex_rf_we),
        .ex_is_load    (ex_is_load),
        .ex_rd         (ex_rd),
        .ex_redirect   (ex_redirect),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .pc_hold       (pc_hold),
        .if_id_hold    (if_id_hold),
        .id_ex_hold    (id_ex_hold),
        .ex_mem_hold   (ex_mem_hold),
        .if_id_bubble  (if_id_bubble),
        .id_ex_bubble  (id_ex_bubble),
        .mem_wb_bubble (mem_wb_bubble),
        .mem_err       (mem_err),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    assign ctl = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold,
                  if_id_bubble, id_ex_bubble, mem_wb_bubble};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1      = 5'd0;
        id_rs2      = 5'd0;
        id_rs1_used = 1'b0;
        id_rs2_used = 1'b0;
        ex_rf_we    = 1'b0;
        ex_is_load  = 1'b0;
        ex_rd       = 5'd0;
        ex_redirect = 1'b0;
        mem_req     = 1'b0;
        mem_ready   = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_is_load  = 1'b1;
        ex_rf_we    = 1'b1;
        ex_rd       = rd;
        id_rs1      = rd;
        id_rs1_used = 1'b1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        set_load_use(5'd3);
        mem_req     = 1'b1;
        ex_redirect = 1'b1;
        #1;
        n_total++;
        if (ctl !== CTL_NONE) $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_NONE);
        else n_pass++;
        step();
        step();
        idle_inputs();
        rst = 1'b0;
        #1;
        n_total++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || mem_err !== 1'b0)
            $display("FAIL reset_state: got stall=%0d flush=%0d err=%b expected 0 0 0",
                     stall_cnt, flush_cnt, mem_err);
        else n_pass++;
        n_total++;
        if (ctl !== CTL_NONE) $display("FAIL reset_idle_ctl: got %b expected %b", ctl, CTL_NONE);
        else n_pass++;
    endtask

    task automatic test_load_use();
        apply_reset();
        set_load_use(5'd5);
        #1;
        n_total++;
        if (ctl !== CTL_LU) $display("FAIL lu_rs1: got %b expected %b", ctl, CTL_LU);
        else n_pass++;
        step();
        n_total++;
        if (stall_cnt !== 4'd1) $display("FAIL lu_stall_cnt1: got %0d expected 1", stall_cnt);
        else n_pass++;
        set_load_use(5'd0);
        #1;
        n_total++;
        if (ctl !== CTL_NONE) $display("FAIL lu_x0: got %b expected %b", ctl, CTL_NONE);
        else n_pass++;
        step();
        idle_inputs();
        ex_is_load  = 1'b1;
        ex_rf_we    = 1'b1;
        ex_rd       = 5'd7;
        id_rs2      = 5'd7;
        id_rs2_used = 1'b1;
        id_rs1      = 5'd7;
        #1;
        n_total++;
        if (ctl !== CTL_LU) $display("FAIL lu_rs2: got %b expected %b", ctl, CTL_LU);
        else n_pass++;
        step();
        id_rs2_used = 1'b0;
        #1;
        n_total++;
        if (ctl !== CTL_NONE) $display("FAIL lu_unused: got %b expected %b", ctl, CTL_NONE);
        else n_pass++;
        step();
        set_load_use(5'd9);
        ex_rf_we = 1'b0;
        #1;
        n_total++;
        if (ctl !== CTL_NONE) $display("FAIL lu_no_we: got %b expected %b", ctl, CTL_NONE);
        else n_pass++;
        step();
        n_total++;
        if (stall_cnt !== 4'd2) $display("FAIL lu_stall_cnt2: got %0d expected 2", stall_cnt);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_redirect();
        apply_reset();
        set_load_use(5'd5);
        ex_redirect = 1'b1;
        #1;
        n_total++;
        if (ctl !== CTL_REDIR) $display("FAIL redir_over_lu: got %b expected %b", ctl, CTL_REDIR);
        else n_pass++;
        step();
        idle_inputs();
        #1;
        n_total++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0)
            $display("FAIL redir_counts: got flush=%0d stall=%0d expected 1 0", flush_cnt, stall_cnt);
        else n_pass++;
        n_total++;
        if (ctl !== CTL_NONE) $display("FAIL redir_after: got %b expected %b", ctl, CTL_NONE);
        else n_pass++;
    endtask

    task automatic test_mem_wait();
        apply_reset();
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (ctl !== CTL_MEM) $display("FAIL mem_wait_c%0d: got %b expected %b", i, ctl, CTL_MEM);
            else n_pass++;
            step();
        end
        mem_ready = 1'b1;
        #1;
        n_total++;
        if (ctl !== CTL_NONE) $display("FAIL mem_release: got %b expected %b", ctl, CTL_NONE);
        else n_pass++;
        step();
        // zero-wait access straight from IDLE must not stall
        #1;
        n_total++;
        if (ctl !== CTL_NONE) $display("FAIL mem_zero_wait: got %b expected %b", ctl, CTL_NONE);
        else n_pass++;
        step();
        idle_inputs();
        #1;
        n_total++;
        if (stall_cnt !== 4'd3 || mem_err !== 1'b0)
            $display("FAIL mem_stall_cnt: got stall=%0d err=%b expected 3 0", stall_cnt, mem_err);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        apply_reset();
        mem_req     = 1'b1;
        mem_ready   = 1'b0;
        ex_redirect = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_total++;
            if (ctl !== CTL_MEM) $display("FAIL sim_mem_c%0d: got %b expected %b", i, ctl, CTL_MEM);
            else n_pass++;
            step();
        end
        mem_ready = 1'b1;
        #1;
        n_total++;
        if (ctl !== CTL_REDIR) $display("FAIL sim_redir: got %b expected %b", ctl, CTL_REDIR);
        else n_pass++;
        step();
        idle_inputs();
        #1;
        n_total++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd2)
            $display("FAIL sim_counts: got flush=%0d stall=%0d expected 1 2", flush_cnt, stall_cnt);
        else n_pass++;
    endtask

    task automatic test_timeout();
        apply_reset();
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        // one IDLE cycle plus MAX_WAIT cycles in WAIT_MEM before ERR
        for (int i = 0; i < MAX_WAIT + 1; i++) begin
            #1;
            n_total++;
            if (ctl !== CTL_MEM || mem_err !== 1'b0)
                $display("FAIL to_wait_c%0d: got ctl=%b err=%b expected %b 0", i, ctl, mem_err, CTL_MEM);
            else n_pass++;
            step();
        end
        n_total++;
        if (mem_err !== 1'b1) $display("FAIL to_err_set: got %b expected 1", mem_err);
        else n_pass++;
        mem_req   = 1'b0;
        mem_ready = 1'b1;
        #1;
        n_total++;
        if (ctl !== CTL_MEM) $display("FAIL to_err_frozen: got %b expected %b", ctl, CTL_MEM);
        else n_pass++;
        step();
        rst = 1'b1;
        #1;
        n_total++;
        if (ctl !== CTL_NONE) $display("FAIL to_rst_ctl: got %b expected %b", ctl, CTL_NONE);
        else n_pass++;
        step();
        rst = 1'b0;
        idle_inputs();
        #1;
        n_total++;
        if (mem_err !== 1'b0 || ctl !== CTL_NONE || stall_cnt !== 4'd0)
            $display("FAIL to_after_rst: got err=%b ctl=%b stall=%0d expected 0 %b 0",
                     mem_err, ctl, stall_cnt, CTL_NONE);
        else n_pass++;
        mem_req   = 1'b1;
        mem_ready = 1'b1;
        #1;
        n_total++;
        if (ctl !== CTL_NONE) $display("FAIL to_idle_state: got %b expected %b", ctl, CTL_NONE);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_saturation();
        apply_reset();
        set_load_use(5'd12);
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 13) begin
                n_total++;
                if (stall_cnt !== 4'd14) $display("FAIL sat_mid: got %0d expected 14", stall_cnt);
                else n_pass++;
            end
        end
        n_total++;
        if (stall_cnt !== 4'd15) $display("FAIL sat_stall: got %0d expected 15", stall_cnt);
        else n_pass++;
        idle_inputs();
        ex_redirect = 1'b1;
        for (int i = 0; i < 18; i++) step();
        n_total++;
        if (flush_cnt !== 4'd15 || stall_cnt !== 4'd15)
            $display("FAIL sat_flush: got flush=%0d stall=%0d expected 15 15", flush_cnt, stall_cnt);
        else n_pass++;
        idle_inputs();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_simultaneous();
        test_timeout();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
